// File: rtl/tdc_fine_stage_if.sv
// Fine-time event stream from tdc_fine_stage to the timestamp assembler.
// Code width follows the delay-line length.
interface tdc_fine_stage_if #(
    parameter int TAPS = 64
);
    localparam int CW = $clog2(TAPS + 1);

    logic [CW-1:0] fine_count;
    logic          fine_sat;
    logic          fine_valid;
    logic          fine_ready;

    modport master (
        output fine_count,
        output fine_sat,
        output fine_valid,
        input  fine_ready
    );

    modport slave (
        input  fine_count,
        input  fine_sat,
        input  fine_valid,
        output fine_ready
    );
endinterface

// File: rtl/tdc_fine_stage.sv
// Carry-chain fine interpolator: capture, optional bubble filter, popcount, LAT-aligned history.
// Define TDC_BUBBLE_FILTER_EN to insert the 3-tap majority filter stage (LAT >= 3).
module tdc_fine_stage #(
    parameter int TAPS = 64,
    parameter int LAT  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              signal_in,
    input  logic              edge_pol,
    input  logic              sample,
    input  logic              clr_ovf,
    output logic              overflow,
    tdc_fine_stage_if.master  fine
);
    localparam int CW = $clog2(TAPS + 1);
`ifdef TDC_BUBBLE_FILTER_EN
    localparam int PIPE = 2;
`else
    localparam int PIPE = 1;
`endif
    // Capture (and filter) stages already cover part of the look-back.
    localparam int HD = LAT - PIPE;

    logic [TAPS-1:0] tap;
`ifdef SYNTHESIS
    (* keep *) logic [TAPS:0] carry;
    assign carry[0] = signal_in;
    for (genvar gi = 0; gi < TAPS; gi++) begin : g_chain
        SB_CARRY u_carry (
            .CO (carry[gi+1]),
            .CI (carry[gi]),
            .I0 (1'b0),
            .I1 (1'b1)
        );
    end
    assign tap = carry[TAPS:1];
`else
    // Each cell forwards CI to CO; without real propagation delay every tap equals the input.
    assign tap = {TAPS{signal_in}};
`endif

    logic [TAPS-1:0] cap_reg;
    always_ff @(posedge clk) begin
        if (!rst_n) cap_reg <= '0;
        else        cap_reg <= tap ^ {TAPS{edge_pol}};
    end

    logic [TAPS-1:0] enc_in;
`ifdef TDC_BUBBLE_FILTER_EN
    logic [TAPS-1:0] maj_next;
    logic [TAPS-1:0] filt_reg;
    for (genvar gi = 0; gi < TAPS; gi++) begin : g_maj
        localparam int LO = (gi == 0) ? 0 : gi - 1;
        localparam int HI = (gi == TAPS - 1) ? TAPS - 1 : gi + 1;
        assign maj_next[gi] = (cap_reg[LO] & cap_reg[gi]) |
                              (cap_reg[LO] & cap_reg[HI]) |
                              (cap_reg[gi] & cap_reg[HI]);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) filt_reg <= '0;
        else        filt_reg <= maj_next;
    end
    assign enc_in = filt_reg;
`else
    assign enc_in = cap_reg;
`endif

    // Population count rather than thermometer position tolerates stray metastable taps.
    logic [CW-1:0] code_next;
    always_comb begin
        code_next = '0;
        for (int i = 0; i < TAPS; i++) begin
            code_next = code_next + CW'(enc_in[i]);
        end
    end

    logic [CW-1:0] hist_reg [HD];
    for (genvar gi = 0; gi < HD; gi++) begin : g_hist
        if (gi == 0) begin : g_head
            always_ff @(posedge clk) begin
                if (!rst_n) hist_reg[gi] <= '0;
                else        hist_reg[gi] <= code_next;
            end
        end else begin : g_tail
            always_ff @(posedge clk) begin
                if (!rst_n) hist_reg[gi] <= '0;
                else        hist_reg[gi] <= hist_reg[gi-1];
            end
        end
    end

    logic [CW-1:0] sel_code;
    logic          sel_sat;
    assign sel_code = hist_reg[HD-1];
    assign sel_sat  = (sel_code == '0) || (sel_code == CW'(TAPS));

    logic [CW-1:0] fine_count_reg;
    logic          fine_sat_reg;
    logic          fine_valid_reg;
    logic          overflow_reg;
    logic          consume;
    logic          load;
    logic          drop;

    assign consume = fine_valid_reg & fine.fine_ready;
    assign load    = sample & (~fine_valid_reg | fine.fine_ready);
    assign drop    = sample & fine_valid_reg & ~fine.fine_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fine_count_reg <= '0;
            fine_sat_reg   <= 1'b0;
            fine_valid_reg <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            if (load) begin
                fine_count_reg <= sel_code;
                fine_sat_reg   <= sel_sat;
                fine_valid_reg <= 1'b1;
            end else if (consume) begin
                fine_valid_reg <= 1'b0;
            end
            if (drop)         overflow_reg <= 1'b1;
            else if (clr_ovf) overflow_reg <= 1'b0;
        end
    end

    assign fine.fine_count = fine_count_reg;
    assign fine.fine_sat   = fine_sat_reg;
    assign fine.fine_valid = fine_valid_reg;
    assign overflow        = overflow_reg;
endmodule

// File: doc/tdc_fine_stage.md
# tdc_fine_stage

Parametrised fine-time interpolator for the TDC: a TAPS-long iCE40 carry-chain delay line driven by the raw, unsynchronised input, captured every clock, encoded to a binary tap count and kept in a LAT-deep history so the synchronised edge detector can retrieve the code for the cycle in which the raw edge arrived. It is the generalised successor of the fixed 64-tap stage and adds selectable edge polarity, saturation flagging, a valid/ready output with overflow detection, and optional bubble filtering. It sits between the raw input pin and the coarse-counter/timestamp assembler.

## Interface
- TAPS, 64: delay-line length in SB_CARRY stages; legal range 8..256.
- LAT, 4: history look-back in clk cycles; legal range 2..16 (3..16 with TDC_BUBBLE_FILTER_EN).
- CW, derived, not overridable: $clog2(TAPS+1), the code width.
- clk  in  1  sampling clock.
- rst_n  in  1  reset, synchronous, active-low.
- signal_in  in  1  raw signal; drives carry[0] directly, no synchronisation.
- edge_pol  in  1  0 = measure rising edge (count ones); 1 = measure falling edge (count zeros).
- sample  in  1  one-cycle strobe from the synchronised edge detector.
- fine_count  out  CW  encoded tap count for the captured event.
- fine_sat  out  1  fine_count is 0 or TAPS, meaning the edge lies outside the chain window.
- fine_valid  out  1  output holds an unconsumed event.
- fine_ready  in  1  consumer accepts the event.
- overflow  out  1  sticky; set when an event was dropped.
- clr_ovf  in  1  clears overflow.

## Operation
- Chain: TAPS SB_CARRY cells with CI=carry[i], I0=0, I1=1, CO=carry[i+1]; tap[i]=carry[i+1].
- Capture: all taps registered every clk edge. edge_pol is applied as an XOR on the captured vector and takes effect from the next capture.
- Encode: population count of the (optionally filtered) vector, CW bits wide, with no truncation. The result is pushed into a LAT-entry history shift register every cycle, regardless of sample.
- Alignment contract: when sample=1 at edge n, the selected code equals the encoding of the taps captured at edge n−LAT. Internal capture, filter and encode stages count toward LAT.
- Output register:
  - On sample, if fine_valid=0 or (fine_valid & fine_ready), load fine_count and fine_sat, and set fine_valid=1.
  - Otherwise keep the held event, discard the new one and set overflow.
  - fine_valid clears on fine_valid & fine_ready when no load occurs in the same cycle.
- overflow: set has priority over clr_ovf in the same cycle. It stays set until cleared.
- The history is never flushed by edge_pol changes.

## Timing
- Reset values: fine_count=0, fine_sat=0, fine_valid=0, overflow=0, and all history entries 0.
- Reset mid-operation clears everything in one edge. A sample within LAT cycles after reset deassertion returns a code of 0 (fine_sat=1).
- Latency: sample at edge n gives fine_valid=1 after edge n (visible in cycle n+1).
- Throughput: one event per cycle when fine_ready is held high.
- Back-to-back samples with fine_ready=0: the first is held and the second sets overflow.
- A sample on the cycle of consumption is accepted with no bubble.
- The tap capture register is the only asynchronous-input crossing. Metastability on individual taps is tolerated by the encoder.

## Configuration
- TDC_BUBBLE_FILTER_EN defined: each captured tap is replaced by the 3-input majority of tap[i−1], tap[i], tap[i+1], with tap[0] and tap[TAPS−1] replicated at the ends. This adds one register stage, absorbed into LAT; minimum LAT is 3.
- Not defined: raw captured taps feed the population count directly; minimum LAT is 2.
- The LAT alignment contract is identical in both builds.

## Test plan
- TAPS=64, LAT=4, edge_pol=0: force the tap vector to 20 ones at edge k, pulse sample at edge k+4 → fine_count=20, fine_sat=0, fine_valid=1 at cycle k+5.
- edge_pol=1 with the tap vector at 20 ones → fine_count=44. All ones with edge_pol=0 → fine_count=64, fine_sat=1.
- fine_ready=0, sample on two consecutive cycles → first event held, overflow=1. Assert clr_ovf and a new drop in the same cycle → overflow stays 1.
- fine_ready=1, sample every cycle for 8 cycles with distinct codes → 8 outputs in order, no overflow.
- Assert rst_n=0 for one cycle mid-stream, then sample 2 cycles after release → fine_count=0, fine_sat=1. All outputs read 0 during reset.
- TDC_BUBBLE_FILTER_EN with the vector 0x0000_0000_0000_FFFB (one bubble at bit 2) → fine_count=16. Without the macro → fine_count=15.
